uart_sim_adapter: RTL and testbench
===================================

Name: uart_sim_adapter

Overview:
- Bit-level UART front end that sits between the DUT's UART pins and the simulation UART byte bridge.
- RX path: deserializes the DUT's txd line into bytes, buffers them in a FIFO, and presents them on a valid/ready byte port (serial_out_*) to the bridge.
- TX path: accepts bytes from the bridge (serial_in_*) and serializes them onto rxd toward the DUT.
- Fixed 8N1 framing by default; the bit period is set by parameter.

Parameters:
- DIV, 16: clock cycles per UART bit; legal range 4..65535, even.
- NSTOP, 1: stop bits transmitted on rxd (1 or 2); the receiver always checks exactly one.
- FIFO_DEPTH, 8: RX byte FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- txd  in  1  DUT UART transmit line; asynchronous; idle high.
- rxd  out  1  UART line driven to the DUT's receive pin; idle high.
- serial_out_valid  out  1  RX FIFO non-empty.
- serial_out_ready  in  1  bridge accepts the head byte.
- serial_out_bits  out  8  RX FIFO head byte.
- serial_in_valid  in  1  bridge offers a byte for transmission.
- serial_in_ready  out  1  transmitter idle and able to accept.
- serial_in_bits  in  8  byte to transmit.

Behaviour:
- Reset values: rxd=1, serial_out_valid=0, serial_out_bits=0, serial_in_ready=0. Both FSMs return to IDLE, FIFO is emptied, counters cleared.
- Reset mid-frame aborts any partial byte; no glitch low on rxd.
- Input sync: txd passes through a 2-flop synchronizer (reset value 1); all RX timing is measured from the synchronized signal.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a high-to-low transition of synced txd loads the bit counter with DIV/2-1 and enters START.
  - START: at count 0 (mid start bit), sample. If high, treat as a glitch and go to IDLE. If low, load DIV-1 and go to DATA.
  - DATA: sample at each count-0, LSB first, 8 samples; after the 8th go to STOP.
  - STOP: sample at mid stop bit. If high, push the byte into the FIFO. If low, framing error: drop the byte, and wait in IDLE until the line returns high before re-arming edge detect.
  - Push on a full FIFO: drop the incoming byte, count an overflow, leave FIFO contents unchanged.
- RX latency: byte visible on serial_out_* one cycle after the stop-bit mid-sample.
- RX FIFO:
  - Pop when serial_out_valid && serial_out_ready.
  - Simultaneous push and pop when full: the pop proceeds and the push is accepted (no drop).
  - Simultaneous push and pop when empty: not possible, since valid=0.
  - serial_out_bits holds the head byte; it is 0 when empty after reset and otherwise holds its last value.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - serial_in_ready=1 only in IDLE.
  - Handshake on valid&&ready at cycle t latches the byte; rxd drives low from t+1 for DIV cycles.
  - Then 8 data bits, LSB first, DIV cycles each; then NSTOP*DIV cycles high.
  - IDLE and ready are re-entered on the cycle after the last stop cycle, so back-to-back frames have no extra idle gap.
  - Frame length: (9+NSTOP)*DIV cycles.
- RX and TX are fully independent; simultaneous activity on both paths is legal.
- Bit counters are $clog2(DIV) bits wide, count down, and reload; they never wrap past 0 unreloaded.

Optional Feature:
- Macro: UART_SIM_ADAPTER_STATS_EN.
- When defined, add ports:
  - frame_err_count  out  16
  - overflow_count  out  16
  - glitch_count  out  16
- Each counter saturates at 16'hFFFF and resets to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package uart_sim_adapter_pkg:
  - UART_DATA_WIDTH=8.
  - rx_state_e and tx_state_e enums (IDLE, START, DATA, STOP).
  - Count-width function.
- Sub-module uart_sim_adapter_fifo: synchronous FIFO (DEPTH, WIDTH), with full/empty flags and same-cycle push/pop, on the same clock and reset.

Test Plan:
- Reset held low, then released with txd=1 and serial_in_valid=0 -> rxd=1, serial_out_valid=0, serial_in_ready=1 one cycle after release.
- DIV=16: offer 8'hA5 on serial_in -> rxd low for 16 cycles starting at t+1, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high; serial_in_ready returns at t+161.
- Drive a valid 8N1 frame 8'h3C on txd, serial_out_ready=1 -> exactly one serial_out handshake with bits=8'h3C.
- Frame 8'h55 with the stop bit held low -> no serial_out_valid; frame_err_count=1 (STATS_EN); the next valid frame 8'h0F is received correctly.
- serial_out_ready=0 and FIFO_DEPTH+2 frames (values 1..10) -> the FIFO holds 1..8, overflow_count=2; draining yields 1..8 in order.
- 3-cycle low pulse on idle txd -> no byte received, glitch_count=1; loop TX into RX (rxd->txd) with 8'hFF and 8'h00 -> both bytes received intact.

Source files
------------

// File: rtl/uart_sim_adapter_pkg.sv
// Shared types and helpers for the bit-level UART simulation adapter.
package uart_sim_adapter_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // Width of a down-counter that must hold DIV-1.
  function automatic int count_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_sim_adapter_fifo.sv
// Synchronous FIFO with a registered head byte that holds its value when empty.
module uart_sim_adapter_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, rd_next;
  logic [AW:0]      count, count_next;
  logic             push_acc, pop_acc;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_acc  = pop && !empty;
  assign push_acc = push && (!full || pop_acc);
  assign rd_next  = pop_acc ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    if (push_acc && !pop_acc) count_next = count + (AW+1)'(1);
    if (!push_acc && pop_acc) count_next = count - (AW+1)'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      count  <= count_next;
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      // A byte written this cycle into the slot that becomes the head bypasses the array.
      if (count_next != '0)
        head <= (push_acc && (rd_next == wr_ptr)) ? push_data : mem[rd_next];
    end
  end

  always_ff @(posedge clock) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_sim_adapter.sv
// 8N1 UART front end between DUT pins and the simulation byte bridge.
// Optional error/overflow/glitch counters under `UART_SIM_ADAPTER_STATS_EN.
module uart_sim_adapter
  import uart_sim_adapter_pkg::*;
#(
  parameter int DIV        = 16,
  parameter int NSTOP      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       txd,
  output logic                       rxd,
  output logic                       serial_out_valid,
  input  logic                       serial_out_ready,
  output logic [UART_DATA_WIDTH-1:0] serial_out_bits,
  input  logic                       serial_in_valid,
  output logic                       serial_in_ready,
  input  logic [UART_DATA_WIDTH-1:0] serial_in_bits
`ifdef UART_SIM_ADAPTER_STATS_EN
  ,
  output logic [15:0]                frame_err_count,
  output logic [15:0]                overflow_count,
  output logic [15:0]                glitch_count
`endif
);

  localparam int DW = UART_DATA_WIDTH;
  localparam int CW = count_width(DIV);
  localparam int IW = $clog2(DW);
  localparam logic [CW-1:0] HALF_BIT = CW'(DIV/2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);

  logic txd_s1, txd_s2, txd_prev;

  rx_state_e      rx_state, rx_state_n;
  logic [CW-1:0]  rx_cnt, rx_cnt_n;
  logic [IW-1:0]  rx_idx, rx_idx_n;
  logic [DW-1:0]  rx_shift;
  logic           rx_sample, rx_done;

  tx_state_e      tx_state, tx_state_n;
  logic [CW-1:0]  tx_cnt, tx_cnt_n;
  logic [IW-1:0]  tx_idx, tx_idx_n, tx_idx_inc;
  logic           tx_sidx, tx_sidx_n;
  logic [DW-1:0]  tx_byte;
  logic           tx_load, rxd_n, ready_n;

  logic fifo_full, fifo_empty, fifo_pop, fifo_push;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txd_s1   <= 1'b1;
      txd_s2   <= 1'b1;
      txd_prev <= 1'b1;
    end else begin
      txd_s1   <= txd;
      txd_s2   <= txd_s1;
      txd_prev <= txd_s2;
    end
  end

  // RX state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
    end
  end

  // Edge detect needs a high-then-low pair, so after a framing error the
  // receiver stays idle until the line has returned high.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sample  = 1'b0;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (txd_prev && !txd_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = HALF_BIT;
        end
      end
      RX_START: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else if (txd_s2) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = FULL_BIT;
          rx_idx_n   = '0;
        end
      end
      RX_DATA: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_sample = 1'b1;
          rx_cnt_n  = FULL_BIT;
          if (rx_idx == IW'(DW-1)) rx_state_n = RX_STOP;
          else rx_idx_n = rx_idx + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != '0) begin
          rx_cnt_n = rx_cnt - 1'b1;
        end else begin
          rx_state_n = RX_IDLE;
          rx_done    = txd_s2;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rx_sample) rx_shift <= {txd_s2, rx_shift[DW-1:1]};
  end

  assign serial_out_valid = !fifo_empty;
  assign fifo_pop         = serial_out_valid && serial_out_ready;
  assign fifo_push        = rx_done && (!fifo_full || fifo_pop);

  uart_sim_adapter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (rx_shift),
    .pop       (fifo_pop),
    .head      (serial_out_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // TX state register; rxd and ready are registered so reset never glitches them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state        <= TX_IDLE;
      tx_cnt          <= '0;
      tx_idx          <= '0;
      tx_sidx         <= 1'b0;
      rxd             <= 1'b1;
      serial_in_ready <= 1'b0;
    end else begin
      tx_state        <= tx_state_n;
      tx_cnt          <= tx_cnt_n;
      tx_idx          <= tx_idx_n;
      tx_sidx         <= tx_sidx_n;
      rxd             <= rxd_n;
      serial_in_ready <= ready_n;
    end
  end

  assign tx_idx_inc = tx_idx + 1'b1;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sidx_n  = tx_sidx;
    rxd_n      = rxd;
    tx_load    = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        rxd_n = 1'b1;
        if (serial_in_valid && serial_in_ready) begin
          tx_state_n = TX_START;
          tx_cnt_n   = FULL_BIT;
          rxd_n      = 1'b0;
          tx_load    = 1'b1;
        end
      end
      TX_START: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - 1'b1;
        end else begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = FULL_BIT;
          tx_idx_n   = '0;
          rxd_n      = tx_byte[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - 1'b1;
        end else begin
          tx_cnt_n = FULL_BIT;
          if (tx_idx == IW'(DW-1)) begin
            tx_state_n = TX_STOP;
            tx_sidx_n  = 1'b0;
            rxd_n      = 1'b1;
          end else begin
            tx_idx_n = tx_idx_inc;
            rxd_n    = tx_byte[tx_idx_inc];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != '0) begin
          tx_cnt_n = tx_cnt - 1'b1;
        end else if (tx_sidx == 1'(NSTOP-1)) begin
          tx_state_n = TX_IDLE;
        end else begin
          tx_sidx_n = 1'b1;
          tx_cnt_n  = FULL_BIT;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    ready_n = (tx_state_n == TX_IDLE);
  end

  always_ff @(posedge clock) begin
    if (tx_load) tx_byte <= serial_in_bits;
  end

`ifdef UART_SIM_ADAPTER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
    return (ev && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic glitch_ev, frame_ev, over_ev;
  assign glitch_ev = (rx_state == RX_START) && (rx_cnt == '0) && txd_s2;
  assign frame_ev  = (rx_state == RX_STOP) && (rx_cnt == '0) && !txd_s2;
  assign over_ev   = rx_done && fifo_full && !fifo_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frame_err_count <= '0;
      overflow_count  <= '0;
      glitch_count    <= '0;
    end else begin
      frame_err_count <= sat_inc(frame_err_count, frame_ev);
      overflow_count  <= sat_inc(overflow_count, over_ev);
      glitch_count    <= sat_inc(glitch_count, glitch_ev);
    end
  end
`endif

endmodule

// File: tb/tb_uart_sim_adapter.sv
// Self-checking bench for uart_sim_adapter: directed steps with randomized bytes.
module tb_uart_sim_adapter;

  localparam int DIV   = 16;
  localparam int NSTOP = 1;
  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       txd_drv = 1'b1;
  logic       loop = 1'b0;
  logic       txd;
  logic       rxd;
  logic       serial_out_valid;
  logic       serial_out_ready = 1'b1;
  logic [7:0] serial_out_bits;
  logic       serial_in_valid = 1'b0;
  logic       serial_in_ready;
  logic [7:0] serial_in_bits = 8'h00;
`ifdef UART_SIM_ADAPTER_STATS_EN
  logic [15:0] frame_err_count, overflow_count, glitch_count;
  int exp_ferr = 0, exp_ovf = 0, exp_glitch = 0;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  assign txd = loop ? rxd : txd_drv;

  uart_sim_adapter #(.DIV(DIV), .NSTOP(NSTOP), .FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .txd              (txd),
    .rxd              (rxd),
    .serial_out_valid (serial_out_valid),
    .serial_out_ready (serial_out_ready),
    .serial_out_bits  (serial_out_bits),
    .serial_in_valid  (serial_in_valid),
    .serial_in_ready  (serial_in_ready),
    .serial_in_bits   (serial_in_bits)
`ifdef UART_SIM_ADAPTER_STATS_EN
    ,
    .frame_err_count  (frame_err_count),
    .overflow_count   (overflow_count),
    .glitch_count     (glitch_count)
`endif
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset && serial_out_valid && serial_out_ready) rx_q.push_back(serial_out_bits);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte to the transmitter and check the whole rxd waveform against the 8N1 frame.
  task automatic tx_frame(input logic [7:0] b, input string tag);
    logic [9:0] fr;
    int n;
    fr = {1'b1, b, 1'b0};
    n = 0;
    @(negedge clock);
    while (serial_in_ready !== 1'b1 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check({tag, " ready_before"}, serial_in_ready, 1);
    serial_in_bits  = b;
    serial_in_valid = 1'b1;
    @(posedge clock);
    #1 serial_in_valid = 1'b0;
    for (int k = 1; k <= (9 + NSTOP) * DIV; k++) begin
      @(negedge clock);
      check({tag, " rxd"}, rxd, fr[(k-1)/DIV]);
      if (k == DIV * 5) check({tag, " ready_mid"}, serial_in_ready, 0);
    end
    @(negedge clock);
    check({tag, " ready_after"}, serial_in_ready, 1);
  endtask

  // Drive one frame on txd with the given stop-bit level.
  task automatic rx_send(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] fr;
    fr = {stop_lvl, b, 1'b0};
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) begin
      txd_drv = fr[i];
      repeat (DIV) @(posedge clock);
      #1;
    end
    txd_drv = 1'b1;
  endtask

  task automatic check_rx(input string tag);
    check({tag, " count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, " byte"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int mcount;

    repeat (4) @(posedge clock);
    @(negedge clock);
    check("reset rxd", rxd, 1);
    check("reset out_valid", serial_out_valid, 0);
    check("reset out_bits", serial_out_bits, 0);
    check("reset in_ready", serial_in_ready, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("post-reset in_ready", serial_in_ready, 1);
    check("post-reset rxd", rxd, 1);
    check("post-reset out_valid", serial_out_valid, 0);

    tx_frame(8'hA5, "tx_a5");
    for (int i = 0; i < 2; i++) tx_frame(8'($urandom), "tx_rand");

    rx_send(8'h3C, 1'b1);
    exp_q.push_back(8'h3C);
    repeat (2 * DIV) @(posedge clock);
    check_rx("rx_3c");

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      rx_send(b, 1'b1);
      exp_q.push_back(b);
      repeat ($urandom_range(1, DIV)) @(posedge clock);
    end
    repeat (2 * DIV) @(posedge clock);
    check_rx("rx_rand");

    rx_send(8'h55, 1'b0);
    repeat (2 * DIV) @(posedge clock);
    @(negedge clock);
    check("ferr out_valid", serial_out_valid, 0);
    check_rx("rx_ferr");
`ifdef UART_SIM_ADAPTER_STATS_EN
    exp_ferr++;
    check("frame_err_count", frame_err_count, exp_ferr);
`endif
    rx_send(8'h0F, 1'b1);
    exp_q.push_back(8'h0F);
    repeat (2 * DIV) @(posedge clock);
    check_rx("rx_0f");

    serial_out_ready = 1'b0;
    mcount = 0;
    for (int v = 1; v <= DEPTH + 2; v++) begin
      rx_send(8'(v), 1'b1);
      if (mcount < DEPTH) begin
        exp_q.push_back(8'(v));
        mcount++;
      end else begin
`ifdef UART_SIM_ADAPTER_STATS_EN
        exp_ovf++;
`endif
      end
    end
    repeat (DIV) @(posedge clock);
    @(negedge clock);
    check("full out_valid", serial_out_valid, 1);
    check("full head", serial_out_bits, 8'h01);
`ifdef UART_SIM_ADAPTER_STATS_EN
    check("overflow_count", overflow_count, exp_ovf);
`endif
    serial_out_ready = 1'b1;
    repeat (3 * DEPTH) @(posedge clock);
    @(negedge clock);
    check("drained out_valid", serial_out_valid, 0);
    check("drained holds last", serial_out_bits, 8'(DEPTH));
    check_rx("rx_drain");

    @(posedge clock);
    #1 txd_drv = 1'b0;
    repeat (3) @(posedge clock);
    #1 txd_drv = 1'b1;
    repeat (3 * DIV) @(posedge clock);
    check_rx("rx_glitch");
`ifdef UART_SIM_ADAPTER_STATS_EN
    exp_glitch++;
    check("glitch_count", glitch_count, exp_glitch);
    check("frame_err_count final", frame_err_count, exp_ferr);
`endif

    loop = 1'b1;
    tx_frame(8'hFF, "loop_ff");
    exp_q.push_back(8'hFF);
    tx_frame(8'h00, "loop_00");
    exp_q.push_back(8'h00);
    b = 8'($urandom);
    tx_frame(b, "loop_rand");
    exp_q.push_back(b);
    repeat (2 * DIV) @(posedge clock);
    check_rx("rx_loop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
